// File: rtl/pwm_shadowed_multi.sv
// Multi-channel PWM sharing one prescaled timer with edge/center alignment.
// Duty, period and prescale are shadowed and only take effect at a period boundary.
module pwm_shadowed_multi #(
   parameter int Resolution    = 8,
   parameter int AddressWidth  = 2,
   parameter int PrescaleWidth = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           ce,
   input  logic [1:0]                     wsel,
   input  logic [AddressWidth-1:0]        addr,
   input  logic [Resolution-1:0]          D,
   input  logic [(2**AddressWidth)-1:0]   pol,
   output logic [(2**AddressWidth)-1:0]   O,
   output logic                           sync
);

   localparam int N = 2**AddressWidth;

   localparam logic [1:0] SEL_DUTY     = 2'd0;
   localparam logic [1:0] SEL_PERIOD   = 2'd1;
   localparam logic [1:0] SEL_PRESCALE = 2'd2;
   localparam logic [1:0] SEL_CONTROL  = 2'd3;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_t;

   logic [Resolution-1:0]    period_pending_reg;
   logic [Resolution-1:0]    period_active_reg;
   logic [PrescaleWidth-1:0] prescale_pending_reg;
   logic [PrescaleWidth-1:0] prescale_active_reg;
   logic                     enable_reg;
   logic                     mode_reg;
   logic [Resolution-1:0]    timer_reg;
   logic [Resolution-1:0]    timer_next;
   logic [PrescaleWidth-1:0] pcnt_reg;
   logic [PrescaleWidth-1:0] pcnt_next;
   dir_t                     dir_reg;
   dir_t                     dir_next;
   logic                     sync_next;
   logic                     load;
   logic                     tick;
   logic                     wr_control;
   logic                     enable_rise;
   logic [PrescaleWidth-1:0] prescale_wdata;
   logic [N-1:0]             raw;

   generate
      if (PrescaleWidth <= Resolution) begin : g_pw_narrow
         assign prescale_wdata = D[PrescaleWidth-1:0];
      end else begin : g_pw_wide
         assign prescale_wdata = {{(PrescaleWidth-Resolution){1'b0}}, D};
      end
   endgenerate

   assign wr_control  = ce && (wsel == SEL_CONTROL);
   assign enable_rise = wr_control && D[0] && !enable_reg;
   assign tick        = (pcnt_reg == prescale_active_reg);

   // Timer/direction next state; load marks the edge where shadows are copied.
   always_comb begin
      timer_next = timer_reg;
      pcnt_next  = pcnt_reg;
      dir_next   = dir_reg;
      sync_next  = 1'b0;
      load       = enable_rise;
      if (!enable_reg) begin
         timer_next = '0;
         pcnt_next  = '0;
         dir_next   = DIR_UP;
         sync_next  = enable_rise;
      end else begin
         if (tick) begin
            pcnt_next = '0;
         end else begin
            pcnt_next = pcnt_reg + 1'b1;
         end
         if (!mode_reg) begin
            dir_next = DIR_UP;
         end
         if (tick) begin
            if (period_active_reg == '0) begin
               timer_next = '0;
               dir_next   = DIR_UP;
            end else if (!mode_reg) begin
               timer_next = (timer_reg == period_active_reg) ? '0 : timer_reg + 1'b1;
            end else if ((timer_reg == period_active_reg) ||
                         ((dir_reg == DIR_DOWN) && (timer_reg != '0))) begin
               timer_next = timer_reg - 1'b1;
               dir_next   = DIR_DOWN;
            end else begin
               timer_next = timer_reg + 1'b1;
               dir_next   = DIR_UP;
            end
            if (timer_next == '0) begin
               sync_next = 1'b1;
               load      = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         period_pending_reg   <= '0;
         period_active_reg    <= '0;
         prescale_pending_reg <= '0;
         prescale_active_reg  <= '0;
         enable_reg           <= 1'b0;
         mode_reg             <= 1'b0;
         timer_reg            <= '0;
         pcnt_reg             <= '0;
         dir_reg              <= DIR_UP;
         sync                 <= 1'b0;
         O                    <= '0;
      end else begin
         timer_reg <= timer_next;
         pcnt_reg  <= pcnt_next;
         dir_reg   <= dir_next;
         sync      <= sync_next;
         O         <= enable_reg ? (raw ^ pol) : '0;
         if (ce && (wsel == SEL_PERIOD)) begin
            period_pending_reg <= D;
         end
         if (ce && (wsel == SEL_PRESCALE)) begin
            prescale_pending_reg <= prescale_wdata;
         end
         // Shadows copy the value held before any write on this same edge.
         if (load) begin
            period_active_reg   <= period_pending_reg;
            prescale_active_reg <= prescale_pending_reg;
         end
         if (wr_control) begin
            enable_reg <= D[0];
            mode_reg   <= D[1];
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_ch
         logic [Resolution-1:0] duty_pending_reg;
         logic [Resolution-1:0] duty_active_reg;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               duty_pending_reg <= '0;
               duty_active_reg  <= '0;
            end else begin
               if (ce && (wsel == SEL_DUTY) && (addr == AddressWidth'(gi))) begin
                  duty_pending_reg <= D;
               end
               if (load) begin
                  duty_active_reg <= duty_pending_reg;
               end
            end
         end

         assign raw[gi] = (duty_active_reg > timer_reg);
      end
   endgenerate

endmodule
